// File: rtl/window_feature_extract.sv
// Window feature extractor: on each new buffer-full event, walks the sample buffer and computes
// mean, min, max, peak-to-peak, energy and (with FEX_ZCR_EN defined) the zero-crossing count.
module window_feature_extract #(
    parameter int N_SAMPLES = 64,
    parameter int RD_LAT    = 1,
    parameter int DC_OFFSET = 2048
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         samples_valid,
    output logic [$clog2(N_SAMPLES)-1:0] buf_addr,
    input  logic [15:0]                  buf_data,
    output logic                         busy,
    output logic                         feat_valid,
    input  logic                         feat_ready,
    output logic [15:0]                  mean_out,
    output logic [15:0]                  min_out,
    output logic [15:0]                  max_out,
    output logic [16:0]                  p2p_out,
    output logic [39:0]                  energy_out,
    output logic [6:0]                   zc_count,
    output logic                         overrun
);
    localparam int AW = $clog2(N_SAMPLES);
    localparam int SW = 16 + AW;
    localparam logic [16:0] DC17 = 17'(DC_OFFSET);

    typedef enum logic [2:0] {IDLE, READ, DRAIN, FINAL, DONE} state_t;
    state_t state_reg, state_next;

    logic          sv_reg, sv_prev_reg;
    logic          rise, start, abort;
    logic [AW-1:0] addr_reg;
    logic [7:0]    drain_cnt_reg;
    logic [RD_LAT-1:0] vpipe_reg;
    logic          sample_valid;

    // A level held high only starts one window; a rise outside IDLE is an overrun.
    assign rise  = sv_reg & ~sv_prev_reg;
    assign start = (state_reg == IDLE) && enable && rise;
    assign abort = !enable && (state_reg == READ || state_reg == DRAIN || state_reg == FINAL);
    assign buf_addr = addr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            sv_reg      <= 1'b0;
            sv_prev_reg <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sv_reg      <= samples_valid;
            sv_prev_reg <= sv_reg;
            if (rise && state_reg != IDLE)
                overrun <= 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        feat_valid = 1'b0;
        case (state_reg)
            IDLE:  if (start) state_next = READ;
            READ: begin
                busy = 1'b1;
                if (!enable) state_next = IDLE;
                else if (addr_reg == AW'(N_SAMPLES - 1)) state_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (!enable) state_next = IDLE;
                else if (drain_cnt_reg == 8'(RD_LAT - 1)) state_next = FINAL;
            end
            FINAL: begin
                busy = 1'b1;
                state_next = enable ? DONE : IDLE;
            end
            DONE: begin
                feat_valid = 1'b1;
                if (feat_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Address walk, drain counter and the read-latency valid pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg      <= '0;
            drain_cnt_reg <= '0;
            vpipe_reg     <= '0;
        end else begin
            addr_reg      <= (state_reg == READ && enable) ? addr_reg + 1'b1 : '0;
            drain_cnt_reg <= (state_reg == DRAIN && enable) ? drain_cnt_reg + 8'd1 : 8'd0;
            if (abort) begin
                vpipe_reg <= '0;
            end else begin
                for (int i = RD_LAT - 1; i > 0; i--)
                    vpipe_reg[i] <= vpipe_reg[i-1];
                vpipe_reg[0] <= (state_reg == READ);
            end
        end
    end

    assign sample_valid = vpipe_reg[RD_LAT-1];

    logic signed [15:0] sample;
    logic signed [16:0] d;
    logic signed [33:0] d_ext;
    logic [33:0]        d_sq;
    logic [40:0]        energy_sum;
    logic signed [SW-1:0] sum_reg;
    logic [39:0]        energy_reg;
    logic signed [15:0] min_reg, max_reg;
    logic               first_reg;
    logic [6:0]         zc_acc;

    assign sample     = buf_data;
    assign d          = {buf_data[15], buf_data} - DC17;
    assign d_ext      = {{17{d[16]}}, d};
    assign d_sq       = d_ext * d_ext;
    assign energy_sum = {1'b0, energy_reg} + {7'd0, d_sq};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg    <= '0;
            energy_reg <= '0;
            min_reg    <= '0;
            max_reg    <= '0;
            first_reg  <= 1'b1;
        end else if (start || abort) begin
            sum_reg    <= '0;
            energy_reg <= '0;
            min_reg    <= '0;
            max_reg    <= '0;
            first_reg  <= 1'b1;
        end else if (sample_valid) begin
            first_reg  <= 1'b0;
            sum_reg    <= sum_reg + {{AW{sample[15]}}, sample};
            energy_reg <= energy_sum[40] ? '1 : energy_sum[39:0];
            if (first_reg || sample < min_reg) min_reg <= sample;
            if (first_reg || sample > max_reg) max_reg <= sample;
        end
    end

`ifdef FEX_ZCR_EN
    logic sign_reg;
    logic [6:0] zc_reg;

    // Negative sign bit of d; d == 0 counts as positive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_reg <= 1'b0;
            zc_reg   <= '0;
        end else if (start || abort) begin
            sign_reg <= 1'b0;
            zc_reg   <= '0;
        end else if (sample_valid) begin
            sign_reg <= d[16];
            if (!first_reg && d[16] != sign_reg) zc_reg <= zc_reg + 7'd1;
        end
    end
    assign zc_acc = zc_reg;
`else
    assign zc_acc = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mean_out   <= '0;
            min_out    <= '0;
            max_out    <= '0;
            p2p_out    <= '0;
            energy_out <= '0;
            zc_count   <= '0;
        end else if (state_reg == FINAL && enable) begin
            mean_out   <= 16'(sum_reg >>> AW);
            min_out    <= min_reg;
            max_out    <= max_reg;
            p2p_out    <= {max_reg[15], max_reg} - {min_reg[15], min_reg};
            energy_out <= energy_reg;
            zc_count   <= zc_acc;
        end
    end
endmodule

// File: tb/tb_window_feature_extract.sv
// Scoreboard bench for window_feature_extract: windows are loaded into a buffer model, expected
// feature sets are queued from an arithmetic reference and checked at every handshake.
module tb_window_feature_extract;
    localparam int N  = 64;
    localparam int DC = 2048;

    logic        clk = 1'b0;
    logic        rst_n, enable, samples_valid, feat_ready;
    logic [5:0]  buf_addr;
    logic [15:0] buf_data;
    logic        busy, feat_valid, overrun;
    logic [15:0] mean_out, min_out, max_out;
    logic [16:0] p2p_out;
    logic [39:0] energy_out;
    logic [6:0]  zc_count;

    logic [15:0] mem [0:N-1];
    int          win [N];

    typedef struct {
        int     mean;
        int     mn;
        int     mx;
        int     p2p;
        longint energy;
        int     zc;
    } feat_t;
    feat_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int out_count = 0;

    window_feature_extract dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .samples_valid(samples_valid),
        .buf_addr(buf_addr), .buf_data(buf_data), .busy(busy), .feat_valid(feat_valid),
        .feat_ready(feat_ready), .mean_out(mean_out), .min_out(min_out), .max_out(max_out),
        .p2p_out(p2p_out), .energy_out(energy_out), .zc_count(zc_count), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Sample buffer with one cycle of registered read latency.
    always @(posedge clk) buf_data <= mem[buf_addr];

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic feat_t model();
        feat_t  f;
        longint s, e, d;
        int     x, mn, mx, zc;
        bit     ps, cs;
        s = 0; e = 0; mn = 0; mx = 0; zc = 0; ps = 1'b0;
        for (int i = 0; i < N; i++) begin
            x = win[i];
            s += x;
            if (i == 0) begin mn = x; mx = x; end
            else begin
                if (x < mn) mn = x;
                if (x > mx) mx = x;
            end
            d = longint'(x) - DC;
            e += d * d;
            cs = (d >= 0);
            if (i > 0 && cs != ps) zc++;
            ps = cs;
        end
        f.mean = (s >= 0) ? int'(s / N) : -int'((-s + N - 1) / N);
        f.mn = mn;
        f.mx = mx;
        f.p2p = mx - mn;
        f.energy = (e > 64'd1099511627775) ? 64'd1099511627775 : e;
`ifdef FEX_ZCR_EN
        f.zc = zc;
`else
        f.zc = 0;
`endif
        return f;
    endfunction

    task automatic load(input int kind);
        for (int i = 0; i < N; i++) begin
            case (kind)
                0: win[i] = 2148;
                1: win[i] = (i % 2 == 0) ? 2148 : 1948;
                2: win[i] = i;
                3: win[i] = int'($urandom_range(65535)) - 32768;
                4: win[i] = DC + int'($urandom_range(200)) - 100;
                5: win[i] = -32768;
                6: win[i] = 32767;
                default: win[i] = int'($urandom_range(4095));
            endcase
            mem[i] = 16'(win[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise samples_valid, measure cycles from the edge that registers the rise to feat_valid.
    task automatic run_window(input bit push, input bit chk_lat, input bit hold);
        int lat;
        if (push) exp_q.push_back(model());
        samples_valid = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        for (int c = 1; c <= 150; c++) begin
            if (c == 3 && !hold) samples_valid = 1'b0;
            tick();
            if (feat_valid) begin
                lat = c;
                break;
            end
        end
        if (chk_lat) check("latency", lat, 67);
    endtask

    // Monitor: every completed handshake is compared with the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && feat_valid && feat_ready) begin
            out_count++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got mean %0d, expected no feature set", $signed(mean_out));
            end else begin
                feat_t f;
                f = exp_q.pop_front();
                check("mean", longint'($signed(mean_out)), f.mean);
                check("min", longint'($signed(min_out)), f.mn);
                check("max", longint'($signed(max_out)), f.mx);
                check("p2p", longint'(p2p_out), f.p2p);
                check("energy", longint'(energy_out), f.energy);
                check("zc", longint'(zc_count), f.zc);
            end
        end
    end

    initial begin
        int found, fv_seen, base;
        rst_n = 1'b1; enable = 1'b0; samples_valid = 1'b0; feat_ready = 1'b1;
        load(0);
        #2 rst_n = 1'b0;
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_feat_valid", feat_valid, 0);
        check("rst_buf_addr", buf_addr, 0);
        check("rst_overrun", overrun, 0);
        check("rst_mean", mean_out, 0);
        check("rst_energy", energy_out, 0);
        @(negedge clk) rst_n = 1'b1;
        tick(); tick();

        load(0); run_window(1, 1, 0); tick(); tick();
        load(1); run_window(1, 1, 0); tick(); tick();
        check("overrun_clear", overrun, 0);

        // Ramp with consumer stalled; a second rise during DONE must flag overrun.
        load(2);
        feat_ready = 1'b0;
        run_window(1, 1, 0);
        for (int c = 0; c < 20; c++) begin
            if (c == 4) samples_valid = 1'b1;
            if (c == 8) samples_valid = 1'b0;
            tick();
            check("hold_valid", feat_valid, 1);
            check("hold_mean", longint'($signed(mean_out)), 31);
            check("hold_p2p", p2p_out, 63);
        end
        check("overrun_set", overrun, 1);
        feat_ready = 1'b1;
        tick(); tick(); tick();

        for (int k = 0; k < 6; k++) begin
            load((k % 3 == 0) ? 3 : ((k % 3 == 1) ? 7 : 4));
            run_window(1, 1, 0);
            tick(); tick();
        end

        // Abort mid-READ.
        load(3);
        samples_valid = 1'b1;
        found = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (c == 3) samples_valid = 1'b0;
            if (buf_addr == 6'd30) begin
                found = 1;
                break;
            end
        end
        check("abort_reach_addr30", found, 1);
        enable = 1'b0;
        tick();
        check("abort_busy", busy, 0);
        check("abort_addr", buf_addr, 0);
        fv_seen = 0;
        repeat (80) begin
            tick();
            if (feat_valid) fv_seen++;
        end
        check("abort_no_valid", fv_seen, 0);
        enable = 1'b1;
        tick();
        load(7); run_window(1, 1, 0); tick(); tick();

        // samples_valid held across two window lengths yields one feature set.
        load(4);
        base = out_count;
        run_window(1, 1, 1);
        repeat (150) tick();
        samples_valid = 1'b0;
        tick(); tick(); tick();
        check("held_sv_outputs", out_count - base, 1);

        // Asynchronous reset between clock edges during READ.
        load(3);
        samples_valid = 1'b1;
        repeat (20) tick();
        samples_valid = 1'b0;
        check("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_feat_valid", feat_valid, 0);
        check("arst_addr", buf_addr, 0);
        check("arst_overrun", overrun, 0);
        check("arst_mean", mean_out, 0);
        check("arst_min", min_out, 0);
        check("arst_max", max_out, 0);
        check("arst_p2p", p2p_out, 0);
        check("arst_energy", energy_out, 0);
        check("arst_zc", zc_count, 0);
        @(negedge clk) rst_n = 1'b1;
        tick(); tick();
        load(5); run_window(1, 1, 0); tick(); tick();
        load(6); run_window(1, 1, 0); tick(); tick();

        for (int c = 0; c < 200; c++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
